// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/result bundle between the main control FSM and
// the multiply/divide engine.
//   Start, Op, A, B          : request (driven by master)
//   Busy, Done, DivZero      : status (driven by slave)
//   Hi, Lo                   : HI/LO result registers (driven by slave)
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic             Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic             DivZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A, B,
        input  Busy, Done, DivZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A, B,
        output Busy, Done, DivZero, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed multiply/divide engine producing HI/LO.
//   clock        : system clock, rising edge
//   reset        : synchronous active-high reset
//   bus.Start    : launch request, sampled only in IDLE
//   bus.Op       : 0 = signed mult, 1 = signed div
//   bus.A/B      : rs/rt operands (multiplicand/dividend, multiplier/divisor)
//   bus.Busy     : high in every state except IDLE
//   bus.Done     : one-cycle pulse, HI/LO valid
//   bus.DivZero  : one-cycle pulse with Done for div by zero
//   bus.Hi/Lo    : HI (upper product / remainder), LO (lower product / quotient)
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic            clock,
    input logic            reset,
    mult_div_unit_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               op_q, op_d;
    logic               divzero_q, divzero_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    assign a_abs = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_abs = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // Shift-add: acc = {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, a_mag_q} : {(WIDTH+1){1'b0}});

    // Restoring divide: acc = {partial remainder, dividend bits / quotient bits}.
    // A borrow out of the trial subtraction keeps the shifted remainder.
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, b_mag_q};
    assign rem_next = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];

    assign quo      = acc_q[WIDTH-1:0];
    assign rem      = acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_mag_d   = a_mag_q;
        b_mag_d   = b_mag_q;
        sign_a_d  = sign_a_q;
        sign_b_d  = sign_b_q;
        op_d      = op_q;
        divzero_d = divzero_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    a_mag_d   = a_abs;
                    b_mag_d   = b_abs;
                    sign_a_d  = bus.A[WIDTH-1];
                    sign_b_d  = bus.B[WIDTH-1];
                    op_d      = bus.Op;
                    cnt_d     = '0;
                    divzero_d = bus.Op && (bus.B == '0);
                    if (!bus.Op) begin
                        acc_d   = {{WIDTH{1'b0}}, b_abs};
                        state_d = MULT;
                    end else if (bus.B == '0) begin
                        state_d = DONE;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, a_abs};
                        state_d = DIV;
                    end
                end
            end
            MULT: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            DIV: begin
                acc_d = {rem_next, acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                // Sign correction feeds HI/LO directly on the edge entering DONE.
                if (!op_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else begin
                    lo_d = (sign_a_q ^ sign_b_q) ? -quo : quo;
                    hi_d = sign_a_q ? -rem : rem;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_mag_q   <= '0;
            b_mag_q   <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            op_q      <= 1'b0;
            divzero_q <= 1'b0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_mag_q   <= a_mag_d;
            b_mag_q   <= b_mag_d;
            sign_a_q  <= sign_a_d;
            sign_b_q  <= sign_b_d;
            op_q      <= op_d;
            divzero_q <= divzero_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.Busy    = (state_q != IDLE);
    assign bus.Done    = (state_q == DONE);
    assign bus.DivZero = (state_q == DONE) && divzero_q;
    assign bus.Hi      = hi_q;
    assign bus.Lo      = lo_q;
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide engine for the MIPS datapath. It produces the HI/LO pair for mult and div.
- The main control FSM launches it with a Start pulse, then stalls in a wait state until Done.
- Internally it sequences a shift-add multiplier and a restoring divider over WIDTH iterations, plus a sign-fix cycle.
- HI/LO are held in this block and read directly by mfhi/mflo.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clock  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- Start  input  1  launch request, sampled only in IDLE
- Op  input  1  0 = mult (signed), 1 = div (signed)
- A  input  WIDTH  rs operand: multiplicand or dividend
- B  input  WIDTH  rt operand: multiplier or divisor
- Busy  output  1  high in every state except IDLE
- Done  output  1  one-cycle pulse; HI/LO valid and updated
- DivZero  output  1  one-cycle pulse coincident with Done when div has B == 0
- Hi  output  WIDTH  HI register (product upper half / remainder)
- Lo  output  WIDTH  LO register (product lower half / quotient)

Behaviour:
- Reset (synchronous, highest priority, any state, including mid-operation):
  - state returns to IDLE;
  - Hi = Lo = 0; Busy = Done = DivZero = 0;
  - iteration counter = 0;
  - any in-flight result is discarded and no Done is issued.
- States are IDLE, MULT, DIV, FIX, DONE.
- IDLE, Start = 1:
  - latch |A|, |B|, sign(A), sign(B) and Op;
  - Op = 0 goes to MULT;
  - Op = 1 with B != 0 goes to DIV;
  - Op = 1 with B == 0 goes straight to DONE with DivZero pending.
- IDLE, Start = 0: stay in IDLE.
- MULT: unsigned shift-add on magnitudes, one bit per cycle, 2*WIDTH-bit accumulator. Exactly WIDTH cycles (counter 0..WIDTH-1), then FIX.
- DIV: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (1 cycle):
  - mult: negate the 2*WIDTH product if sign(A) != sign(B);
  - div: negate the quotient if signs differ; the remainder takes the sign of the dividend.
  - Go to DONE.
- DONE (1 cycle):
  - Hi/Lo are written on the edge entering DONE; Done = 1 during DONE.
  - DivZero = 1 only for the B == 0 path, and then Hi/Lo are left unchanged.
  - Go to IDLE.
- Latency, counted from the edge sampling Start (edge 0):
  - normal op: Done is high in the cycle after edge WIDTH+2 (34 cycles for WIDTH = 32);
  - divide-by-zero: Done is high in the cycle after edge 1.
- Start while Busy = 1 (including the DONE cycle) is ignored and not queued.
- A and B may change after the Start edge; the latched copies are used.
- Arithmetic rules:
  - mult result is the full 2*WIDTH-bit two's-complement product, no overflow flag;
  - div of most-negative by -1: quotient wraps to 0x80000000, remainder 0, no exception.
- Hi/Lo hold their values between operations; only a completed op or reset changes them.
- Busy is a function of state only. Done and DivZero are registered-state decodes and are glitch-free.

Test Plan:
- Reset: assert reset 2 cycles, then check Hi = Lo = 0x00000000 and Busy = Done = DivZero = 0. Pulse reset at MULT iteration 10: next cycle IDLE, Hi = Lo = 0, no Done ever follows.
- mult, A = 7, B = 0xFFFFFFFD (-3), Start at edge 0: Busy from cycle 1, Done exactly in cycle 34, Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB. Also 0x80000000 * 0x80000000 gives Hi = 0x40000000, Lo = 0x00000000.
- div, A = 0xFFFFFFF9 (-7), B = 2: Done in cycle 34, Lo = 0xFFFFFFFD (-3), Hi = 0xFFFFFFFF (-1). Also 0x80000000 / 0xFFFFFFFF gives Lo = 0x80000000, Hi = 0, DivZero = 0.
- div by zero, Hi/Lo preloaded 0x11111111/0x22222222, A = 5, B = 0: Done = DivZero = 1 in cycle 1 for one cycle, Hi/Lo unchanged.
- Start held high continuously with a new Op/A/B on every cycle during an operation: only the first request executes, result matches the first operands, and the next op launches from IDLE after DONE.
- Back-to-back: mult 3*4 then div 100/7, second Start the cycle after Done. Results: Lo = 12, Hi = 0; then Lo = 14, Hi = 2. Each Done is exactly one cycle.
